// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Define BRANCH_PREDICTOR_STATS_EN to add the stat_updates/stat_mispreds counters.
`timescale 1ns/1ps
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_mispred,
  input  logic        bp_flush
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispreds
`endif
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic             kern;
    logic [TAG_W-1:0] tag;
    logic [1:0]       ctr;
    logic [31:0]      target;
  } entry_t;

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] rd_idx, up_idx;
  logic [TAG_W-1:0] rd_tag, up_tag;
  entry_t           rd_e, up_e;
  logic             upd_hit;

  assign rd_idx = if_pc[IDX_W+1:2];
  assign rd_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Reads come straight off the registered table; a same-cycle update is not forwarded.
  always_comb begin
    rd_e        = tbl[rd_idx];
    up_e        = tbl[up_idx];
    pred_hit    = rd_e.valid && (rd_e.tag == rd_tag) && (rd_e.kern == if_pc[31]);
    pred_taken  = pred_hit && rd_e.ctr[1];
    pred_target = pred_hit ? rd_e.target : 32'd0;
    upd_hit     = up_e.valid && (up_e.tag == up_tag) && (up_e.kern == upd_pc[31]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i].valid  <= 1'b0;
        tbl[i].kern   <= 1'b0;
        tbl[i].tag    <= '0;
        tbl[i].ctr    <= 2'd1;
        tbl[i].target <= 32'd0;
      end
    end else if (bp_flush) begin
      // Flush drops only the valid bits; counters and targets are left as they are.
      for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (up_e.ctr != 2'd3) tbl[up_idx].ctr <= up_e.ctr + 2'd1;
          tbl[up_idx].target <= upd_target;
        end else if (up_e.ctr != 2'd0) begin
          tbl[up_idx].ctr <= up_e.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        tbl[up_idx].valid  <= 1'b1;
        tbl[up_idx].kern   <= upd_pc[31];
        tbl[up_idx].tag    <= up_tag;
        tbl[up_idx].ctr    <= 2'd2;
        tbl[up_idx].target <= upd_target;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_updates  <= 32'd0;
      stat_mispreds <= 32'd0;
    end else if (upd_valid) begin
      stat_updates <= stat_updates + 32'd1;
      if (upd_mispred) stat_mispreds <= stat_mispreds + 32'd1;
    end
  end
  logic unused_pc;
  assign unused_pc = ^{if_pc, upd_pc};
`else
  logic unused_pc;
  assign unused_pc = ^{if_pc, upd_pc, upd_mispred};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (default ENTRIES=64, TAG_W=8).
`timescale 1ns/1ps
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = 32'd0, upd_target = 32'd0;
  logic        upd_taken = 1'b0, upd_mispred = 1'b0, bp_flush = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_updates, stat_mispreds;
`endif

  int total = 0;
  int bad   = 0;
  int exp_upd = 0;
  int exp_misp = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;
  exp_t sb[$];

  branch_predictor #(.ENTRIES(64), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .bp_flush(bp_flush)
`ifdef BRANCH_PREDICTOR_STATS_EN
    , .stat_updates(stat_updates), .stat_mispreds(stat_mispreds)
`endif
  );

  always #5 clk = ~clk;

  task automatic look(input string nm, input logic [31:0] pc, input logic h, input logic t,
                      input logic [31:0] tg);
    exp_t e;
    sb.push_back('{name: nm, hit: h, taken: t, tgt: tg});
    if_pc = pc;
    #1;
    e = sb.pop_front();
    total++;
    assert ({pred_hit, pred_taken, pred_target} === {e.hit, e.taken, e.tgt})
    else begin
      bad++;
      $error("FAIL %s: got hit=%0b taken=%0b tgt=%h, want hit=%0b taken=%0b tgt=%h",
             e.name, pred_hit, pred_taken, pred_target, e.hit, e.taken, e.tgt);
    end
  endtask

  // Drive one update for one edge; inputs change #1 after the rising edge.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input logic tk,
                     input logic mp, input logic fl);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tg; upd_taken = tk;
    upd_mispred = mp; bp_flush = fl;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_mispred = 1'b0; bp_flush = 1'b0; upd_taken = 1'b0;
    exp_upd++;
    if (mp) exp_misp++;
  endtask

  task automatic chk_stats(input string nm);
`ifdef BRANCH_PREDICTOR_STATS_EN
    total++;
    assert ({stat_updates, stat_mispreds} === {exp_upd[31:0], exp_misp[31:0]})
    else begin
      bad++;
      $error("FAIL %s: got upd=%0d misp=%0d, want upd=%0d misp=%0d",
             nm, stat_updates, stat_mispreds, exp_upd, exp_misp);
    end
`else
    if (nm.len() == 0) $display("stats disabled");
`endif
  endtask

  initial begin
    look("reset_out", 32'h0040_0010, 1'b0, 1'b0, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    look("post_reset_miss", 32'h0040_0010, 1'b0, 1'b0, 32'd0);
    chk_stats("stats_reset");

    upd(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b1, 1'b0);
    look("alloc_hit", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0000_dead, 1'b0, 1'b1, 1'b0);
    look("nt_ctr1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0000_dead, 1'b0, 1'b0, 1'b0);
    look("nt_ctr0", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0000_dead, 1'b0, 1'b0, 1'b0);
    upd(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 1'b0);
    look("sat0_then_t_ctr1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
    upd(32'h0040_0010, 32'h0040_0200, 1'b1, 1'b0, 1'b0);
    look("t_ctr2_newtgt", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    upd(32'h0040_0010, 32'h0040_0200, 1'b1, 1'b0, 1'b0);
    upd(32'h0040_0010, 32'h0040_0200, 1'b1, 1'b0, 1'b0);
    upd(32'h0040_0010, 32'h0000_beef, 1'b0, 1'b1, 1'b0);
    look("sat3_then_nt_ctr2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
    chk_stats("stats_mid");

    // Same-cycle lookup and update of one index sees the old contents.
    upd_valid = 1'b1; upd_pc = 32'h0040_0030; upd_target = 32'h0040_0300; upd_taken = 1'b1;
    look("no_bypass", 32'h0040_0030, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_taken = 1'b0; exp_upd++;
    look("after_bypass_edge", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_0300);

    upd(32'h0040_0110, 32'h0040_0400, 1'b1, 1'b0, 1'b0);
    look("alias_old_miss", 32'h0040_0010, 1'b0, 1'b0, 32'd0);
    look("alias_new_hit", 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0400);

    upd(32'h8000_0010, 32'h8000_0500, 1'b1, 1'b0, 1'b0);
    look("kernel_mismatch", 32'h0000_0010, 1'b0, 1'b0, 32'd0);
    look("kernel_hit", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0500);

    upd(32'h0050_0010, 32'h0000_1111, 1'b0, 1'b0, 1'b0);
    look("nt_miss_keeps", 32'h8000_0010, 1'b1, 1'b1, 32'h8000_0500);
    upd(32'h0040_0050, 32'h0000_2222, 1'b0, 1'b0, 1'b0);
    look("nt_miss_no_alloc", 32'h0040_0050, 1'b0, 1'b0, 32'd0);

    upd(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b0, 1'b0);
    look("pre_flush_hit", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
    upd(32'h0040_0020, 32'h0040_0600, 1'b1, 1'b1, 1'b1);
    look("flush_old_miss", 32'h0040_0010, 1'b0, 1'b0, 32'd0);
    look("flush_beats_upd", 32'h0040_0020, 1'b0, 1'b0, 32'd0);
    look("flush_other_miss", 32'h0040_0030, 1'b0, 1'b0, 32'd0);
    chk_stats("stats_flush");

    upd(32'h0040_0010, 32'h0040_0700, 1'b1, 1'b0, 1'b0);
    look("realloc_after_flush", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0700);
    reset = 1'b0;
    exp_upd = 0; exp_misp = 0;
    look("async_reset_out", 32'h0040_0010, 1'b0, 1'b0, 32'd0);
    chk_stats("stats_async_reset");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    look("rerelease_empty", 32'h0040_0010, 1'b0, 1'b0, 32'd0);
    upd(32'h0040_0010, 32'h0040_0800, 1'b1, 1'b1, 1'b0);
    look("first_upd_after_reset", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0800);
    chk_stats("stats_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64: number of table entries, a power of two in the range 4..256.
REQ-002 The block SHALL have parameter TAG_W, default 8: number of stored PC tag bits, range 1..(29 - log2(ENTRIES)).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port if_pc, input, 32 bits: fetch-stage PC used for lookup.
REQ-006 The block SHALL have port pred_hit, output, 1 bit: the lookup matched a valid entry.
REQ-007 The block SHALL have port pred_taken, output, 1 bit: predict taken.
REQ-008 The block SHALL have port pred_target, output, 32 bits: predicted target.
REQ-009 The block SHALL have port upd_valid, input, 1 bit: a branch resolved in EX this cycle.
REQ-010 The block SHALL have ports upd_pc (input, 32 bits) and upd_target (input, 32 bits): resolved branch PC and taken target.
REQ-011 The block SHALL have port upd_taken, input, 1 bit: the branch outcome.
REQ-012 The block SHALL have port upd_mispred, input, 1 bit: EX detected a misprediction for this branch.
REQ-013 The block SHALL have port bp_flush, input, 1 bit: invalidate all entries.

Function
REQ-014 The table index SHALL be pc[IDX_W+1:2] with IDX_W = log2(ENTRIES), and the tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-015 Each entry SHALL hold: valid, a kernel bit (pc[31]), a tag, a 2-bit saturating counter and a 32-bit target.
REQ-016 Lookup SHALL be combinational from the registered table, with zero-cycle latency.
- pred_hit = valid & tag match & kernel-bit match.
- pred_taken = pred_hit & counter[1].
- pred_target = entry target when pred_hit, else 0.
REQ-017 An update with a hit (same hit rule applied to upd_pc) SHALL move the counter:
- upd_taken: increment, saturating at 3.
- not taken: decrement, saturating at 0.
- target is rewritten only when upd_taken.
REQ-018 An update with a miss and upd_taken=1 SHALL allocate or overwrite the indexed entry: valid=1, tag and kernel bit from upd_pc, counter=2, target=upd_target.
REQ-019 An update with a miss and upd_taken=0 SHALL leave the table unchanged.
REQ-020 Lookup and update of the same index in the same cycle SHALL return the pre-update contents; there is no bypass.
REQ-021 On bp_flush=1, all valid bits SHALL clear at the next edge; flush SHALL take priority over a simultaneous update.
REQ-022 Counters and targets SHALL not be cleared by bp_flush; only the valid bits are cleared.

Reset
REQ-023 While reset=0, all valid bits SHALL be 0, all counters 1, all targets 0, and all statistics counters 0, asynchronously.
REQ-024 While reset=0, outputs SHALL read pred_hit=0, pred_taken=0, pred_target=0.
REQ-025 Releasing reset mid-operation SHALL leave the table empty; the first update after release SHALL be processed normally.

Configuration
REQ-026 With macro BRANCH_PREDICTOR_STATS_EN defined, the block SHALL add outputs stat_updates and stat_mispreds, each 32 bits, wrapping.
- stat_updates increments on upd_valid.
- stat_mispreds increments on upd_valid & upd_mispred.
- Both counters count during bp_flush.
REQ-027 Without BRANCH_PREDICTOR_STATS_EN, those ports and registers SHALL not exist and table behaviour SHALL be identical.

Verification
REQ-028 Reset, then if_pc=0x0040_0010 -> pred_hit=0, pred_taken=0, pred_target=0.
REQ-029 Update with upd_pc=0x0040_0010, taken, target 0x0040_0100 -> next cycle lookup of 0x0040_0010 gives hit=1, taken=1, target=0x0040_0100.
REQ-030 Same branch updated not-taken twice -> counter goes 2->1->0; pred_taken=0 after the first update, pred_hit stays 1.
REQ-031 Aliasing (ENTRIES=64, TAG_W=8): upd_pc=0x0040_0010 then 0x0040_0110 (same index, different tag), both taken -> lookup 0x0040_0010 misses; lookup 0x0040_0110 hits.
REQ-032 Kernel bit: entry allocated at 0x8000_0010 -> lookup of 0x0000_0010 gives pred_hit=0.
REQ-033 bp_flush=1 together with a taken update at 0x0040_0020 -> next cycle both 0x0040_0010 and 0x0040_0020 miss; with STATS_EN, stat_updates has incremented by 1.
